// File: rtl/op_fetch_sequencer.sv
// Opcode-fetch front end and T-state/M-cycle sequencer.
// A small prefetch FIFO feeds the current opcode register at the fetch point
// (M1T1). The sequencer walks TSTATES T-states per M-cycle for the number of
// M-cycles the decoder requests, tags the opcode that follows a prefix opcode,
// and pops the next opcode back-to-back when one is buffered.
//
// Handshake: op_in is accepted on a rising clk edge where op_in_valid and
// op_in_ready are both high; op_in_ready is simply "FIFO not full" and never
// depends on op_in_valid. A word offered while op_in_ready is low is dropped.
module op_fetch_sequencer #(
  parameter int              DATA_W     = 8,
  parameter int              FIFO_DEPTH = 2,
  parameter int              TSTATES    = 4,
  parameter int              MAX_MCYC   = 6,
  parameter int              PREFIX_EN  = 1,
  parameter logic [DATA_W-1:0] PREFIX_OP = 8'hCB
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DATA_W-1:0]                 op_in,
  input  logic                              op_in_valid,
  output logic                              op_in_ready,
  input  logic [$clog2(MAX_MCYC+1)-1:0]     mcycles_req,
  input  logic                              stall,
  output logic [DATA_W-1:0]                 op,
  output logic                              op_prefixed,
  output logic [$clog2(TSTATES)-1:0]        t_state,
  output logic [$clog2(MAX_MCYC)-1:0]       m_cycle,
  output logic                              m1t1,
  output logic                              fetch_wait,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
  output logic [1:0]                        state_dbg
);

  localparam int MC_W  = $clog2(MAX_MCYC+1);
  localparam int T_W   = $clog2(TSTATES);
  localparam int M_W   = $clog2(MAX_MCYC);
  localparam int CNT_W = $clog2(FIFO_DEPTH+1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [T_W-1:0]     t_q, t_d;
  logic [M_W-1:0]     m_q, m_d;
  logic [MC_W-1:0]    mcyc_q, mcyc_eff;
  logic               latch_en;
  logic               pop, push;
  logic               empty, full;
  logic [DATA_W-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  logic [CNT_W-1:0]   count;

  assign empty       = (count == '0);
  assign full        = (count == CNT_W'(FIFO_DEPTH));
  assign op_in_ready = !full;
  assign push        = op_in_valid && !full;

  // Decoder request made legal: 0 -> 1, clamp to MAX_MCYC, prefix forced to 1.
  always_comb begin
    mcyc_eff = mcycles_req;
    if ((PREFIX_EN != 0) && (op == PREFIX_OP) && !op_prefixed)
      mcyc_eff = MC_W'(1);
    else if (mcycles_req == '0)
      mcyc_eff = MC_W'(1);
    else if (mcycles_req > MC_W'(MAX_MCYC))
      mcyc_eff = MC_W'(MAX_MCYC);
  end

  // Next-state, counter advance and pop decision.
  always_comb begin
    state_d  = state_q;
    t_d      = t_q;
    m_d      = m_q;
    pop      = 1'b0;
    latch_en = 1'b0;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        t_d = '0;
        m_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (!stall) begin
          if ((t_q == '0) && (m_q == '0))
            latch_en = 1'b1;
          if (t_q == T_W'(TSTATES-1)) begin
            t_d = '0;
            if ((MC_W'(m_q) + MC_W'(1)) == mcyc_q) begin
              m_d = '0;
              if (!empty) pop = 1'b1;
              else        state_d = FETCH;
            end else begin
              m_d = m_q + M_W'(1);
            end
          end else begin
            t_d = t_q + T_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer registers: state, counters, M-cycle latch, current opcode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      t_q         <= '0;
      m_q         <= '0;
      mcyc_q      <= MC_W'(1);
      op          <= '0;
      op_prefixed <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      m_q     <= m_d;
      if (latch_en)
        mcyc_q <= mcyc_eff;
      if (pop) begin
        op          <= mem[rd_ptr];
        op_prefixed <= (PREFIX_EN != 0) && (op == PREFIX_OP) && !op_prefixed;
      end
    end
  end

  // FIFO storage; contents need no reset since pointers and count do.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= op_in;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign t_state    = t_q;
  assign m_cycle    = m_q;
  assign m1t1       = (state_q == RUN) && (t_q == '0) && (m_q == '0);
  assign fetch_wait = (state_q == FETCH) && empty;
  assign fifo_count = count;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_op_fetch_sequencer.sv
// Bench for op_fetch_sequencer: directed scenarios followed by random traffic,
// every cycle compared against an instruction-level reference model.
module tb_op_fetch_sequencer;

  localparam int          DATA_W     = 8;
  localparam int          FIFO_DEPTH = 2;
  localparam int          TSTATES    = 4;
  localparam int          MAX_MCYC   = 6;
  localparam logic [7:0]  PREFIX_OP  = 8'hCB;

  logic        clk;
  logic        rst;
  logic [7:0]  op_in;
  logic        op_in_valid;
  logic        op_in_ready;
  logic [2:0]  mcycles_req;
  logic        stall;
  logic [7:0]  op;
  logic        op_prefixed;
  logic [1:0]  t_state;
  logic [2:0]  m_cycle;
  logic        m1t1;
  logic        fetch_wait;
  logic [1:0]  fifo_count;
  logic [1:0]  state_dbg;

  op_fetch_sequencer #(
    .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .TSTATES(TSTATES),
    .MAX_MCYC(MAX_MCYC), .PREFIX_EN(1), .PREFIX_OP(PREFIX_OP)
  ) dut (
    .clk(clk), .rst(rst), .op_in(op_in), .op_in_valid(op_in_valid),
    .op_in_ready(op_in_ready), .mcycles_req(mcycles_req), .stall(stall),
    .op(op), .op_prefixed(op_prefixed), .t_state(t_state), .m_cycle(m_cycle),
    .m1t1(m1t1), .fetch_wait(fetch_wait), .fifo_count(fifo_count),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard / reference model ----------------
  // mode: 0 idle, 1 waiting at fetch point, 2 executing an instruction.
  // pos counts non-stalled cycles into the current instruction, so
  // T-state = pos % TSTATES and M-cycle = pos / TSTATES.
  logic [DATA_W-1:0] exp_q[$];
  int          mode;
  int          pos;
  int          mcyc;
  logic [7:0]  cur_op;
  bit          cur_pref;
  int          n_tests;
  int          n_fail;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    mode     = 0;
    pos      = 0;
    mcyc     = 1;
    cur_op   = 8'h00;
    cur_pref = 1'b0;
  endtask

  function automatic int legal_mcyc(input int r);
    if (cur_op == PREFIX_OP && !cur_pref) return 1;
    if (r == 0) return 1;
    if (r > MAX_MCYC) return MAX_MCYC;
    return r;
  endfunction

  task automatic model_pop();
    bit np;
    np       = (cur_op == PREFIX_OP) && !cur_pref;
    cur_op   = exp_q.pop_front();
    cur_pref = np;
    pos      = 0;
    mode     = 2;
  endtask

  // One clock edge of the model, using the inputs held across that edge.
  task automatic model_step();
    bit do_push;
    do_push = op_in_valid && (exp_q.size() < FIFO_DEPTH);
    case (mode)
      0: mode = 1;
      1: if (exp_q.size() > 0) model_pop();
      default: begin
        if (!stall) begin
          if (pos == 0) mcyc = legal_mcyc(int'(mcycles_req));
          pos++;
          if (pos == mcyc * TSTATES) begin
            pos = 0;
            if (exp_q.size() > 0) model_pop();
            else mode = 1;
          end
        end
      end
    endcase
    if (do_push) exp_q.push_back(op_in);
  endtask

  task automatic compare_all();
    check("op",          32'(op),          32'(cur_op));
    check("op_prefixed", 32'(op_prefixed), 32'(cur_pref));
    check("t_state",     32'(t_state),     32'(pos % TSTATES));
    check("m_cycle",     32'(m_cycle),     32'(pos / TSTATES));
    check("m1t1",        32'(m1t1),        32'((mode == 2) && (pos == 0)));
    check("fetch_wait",  32'(fetch_wait),  32'((mode == 1) && (exp_q.size() == 0)));
    check("fifo_count",  32'(fifo_count),  32'(exp_q.size()));
    check("op_in_ready", 32'(op_in_ready), 32'(exp_q.size() < FIFO_DEPTH));
  endtask

  // Advance one clock; check outputs half a period after the edge.
  task automatic cycle();
    @(posedge clk);
    if (rst) model_step();
    @(negedge clk);
    compare_all();
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input bit v, input logic [7:0] d, input int req, input bit st);
    op_in_valid = v;
    op_in       = d;
    mcycles_req = 3'(req);
    stall       = st;
  endtask

  task automatic push_word(input logic [7:0] d, input int req);
    drive(1'b1, d, req, 1'b0);
    cycle();
    drive(1'b0, 8'h00, req, 1'b0);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Asynchronous reset between edges, checked before any clock edge arrives.
  task automatic async_reset();
    #2;
    rst = 1'b0;
    drive(1'b0, 8'h00, 1, 1'b0);
    #1;
    model_reset();
    compare_all();
    check("reset_op_zero", 32'(op), 32'h0);
    run(2);
    rst = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_tests = 0;
    n_fail  = 0;
    model_reset();
    rst = 1'b0;
    drive(1'b0, 8'h00, 1, 1'b0);
    #3;
    compare_all();
    run(2);
    rst = 1'b1;

    // Single NOP, one M-cycle; then idle at the fetch point.
    run(2);
    push_word(8'h00, 1);
    run(10);

    // Two preloaded opcodes, back-to-back with no bubble.
    push_word(8'h3E, 2);
    push_word(8'h04, 2);
    run(3);
    mcycles_req = 3'd1;
    run(14);

    // Prefix sequence CB, 37, 00 plus a CB CB pair.
    push_word(8'hCB, 2);
    push_word(8'h37, 2);
    run(4);
    push_word(8'h00, 2);
    run(20);
    push_word(8'hCB, 2);
    push_word(8'hCB, 2);
    run(6);
    push_word(8'h12, 2);
    run(24);

    // Stall at M1T1 and at M1T3.
    push_word(8'h21, 1);
    stall = 1'b1;
    run(3);
    stall = 1'b0;
    run(2);
    stall = 1'b1;
    run(3);
    stall = 1'b0;
    run(6);

    // Overflow: three pushes into a two-entry FIFO during a long instruction.
    push_word(8'h55, 6);
    run(2);
    drive(1'b1, 8'hA1, 6, 1'b0); cycle();
    drive(1'b1, 8'hA2, 6, 1'b0); cycle();
    drive(1'b1, 8'hA3, 6, 1'b0); cycle();
    drive(1'b0, 8'h00, 0, 1'b0);
    run(60);

    // Reset mid-instruction with one entry queued.
    push_word(8'h77, 3);
    push_word(8'h88, 3);
    run(5);
    async_reset();
    run(4);

    // Random traffic with occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 99) < 40),
            ($urandom_range(0, 3) == 0) ? PREFIX_OP : 8'($urandom_range(0, 255)),
            int'($urandom_range(0, 7)),
            ($urandom_range(0, 99) < 15));
      cycle();
      if ((i % 700) == 699) async_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
